// File: rtl/run_controller.sv
// -----------------------------------------------------------------------------
// run_controller
//
// Run/step/halt controller for a small CPU. It turns a run switch, a bouncy
// single-step button, a CPU halt request and a PC breakpoint into a registered
// one-cycle CPU advance enable (cpu_en). It also counts the enables it issues.
//
// Ports
//   clock        in   single clock for all state
//   reset        in   asynchronous, active-high reset
//   run_sw       in   asynchronous run switch (1 = run)
//   step_btn     in   asynchronous, bouncy single-step button
//   halt_req     in   synchronous halt request level from the CPU
//   pc           in   [31:0] current CPU program counter
//   bp_addr      in   [31:0] breakpoint address
//   bp_en        in   breakpoint enable
//   rate_sel     in   [1:0] run pulse period select: 1/4/16/64 cycles
//   cpu_en       out  one-cycle CPU advance enable (registered)
//   state        out  [1:0] IDLE=00 RUN=01 STEP=10 HALT=11
//   halted       out  high exactly while state is HALT
//   halt_cause   out  [1:0] 00 none, 01 halt_req, 10 breakpoint
//   cycle_count  out  [31:0] number of cpu_en pulses issued (saturating)
// -----------------------------------------------------------------------------
module run_controller #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic        halt_req,
  input  logic [31:0] pc,
  input  logic [31:0] bp_addr,
  input  logic        bp_en,
  input  logic [1:0]  rate_sel,
  output logic        cpu_en,
  output logic [1:0]  state,
  output logic        halted,
  output logic [1:0]  halt_cause,
  output logic [31:0] cycle_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_HALT = 2'b11
  } state_e;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_REQ  = 2'b01;
  localparam logic [1:0] CAUSE_BP   = 2'b10;

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  // ---------------------------------------------------------------------------
  // Two-flop synchronizers for the asynchronous switch and button
  // ---------------------------------------------------------------------------
  logic [1:0] run_sync_q;
  logic [1:0] step_sync_q;
  logic       run_s;
  logic       step_s;

  // NOTE: clocked state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_sync_q  <= 2'b00;
      step_sync_q <= 2'b00;
    end else begin
      run_sync_q  <= {run_sync_q[0], run_sw};
      step_sync_q <= {step_sync_q[0], step_btn};
    end
  end

  assign run_s  = run_sync_q[1];
  assign step_s = step_sync_q[1];

  // ---------------------------------------------------------------------------
  // Step debouncer: a level change is adopted only after DEBOUNCE_CYCLES
  // consecutive differing cycles; any agreeing cycle restarts the count.
  // ---------------------------------------------------------------------------
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            db_lvl_q, db_lvl_d;
  logic            step_pulse_q, step_pulse_d;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    db_cnt_d     = db_cnt_q;
    db_lvl_d     = db_lvl_q;
    step_pulse_d = 1'b0;
    if (step_s == db_lvl_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      // This is the DEBOUNCE_CYCLES-th differing cycle: adopt the new level.
      db_lvl_d     = step_s;
      db_cnt_d     = '0;
      step_pulse_d = step_s;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      db_cnt_q     <= '0;
      db_lvl_q     <= 1'b0;
      step_pulse_q <= 1'b0;
    end else begin
      db_cnt_q     <= db_cnt_d;
      db_lvl_q     <= db_lvl_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Run rate: tick when the counter has reached period-1. The >= compare makes
  // a mid-run switch to a shorter period tick on the very next cycle.
  // ---------------------------------------------------------------------------
  logic [5:0] rate_cnt_q, rate_cnt_d;
  logic [5:0] period_m1;
  logic       tick;
  logic       bp_hit;

  always_comb begin
    period_m1 = 6'd0;
    case (rate_sel)
      2'd0:    period_m1 = 6'd0;
      2'd1:    period_m1 = 6'd3;
      2'd2:    period_m1 = 6'd15;
      default: period_m1 = 6'd63;
    endcase
  end

  assign tick   = (rate_cnt_q >= period_m1);
  assign bp_hit = bp_en && (pc == bp_addr);

  // ---------------------------------------------------------------------------
  // Main FSM: next-state decode, then one register block for all FSM outputs
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic        cpu_en_q, cpu_en_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] cycle_count_q, cycle_count_d;

  always_comb begin
    state_d    = state_q;
    cpu_en_d   = 1'b0;
    cause_d    = cause_q;
    rate_cnt_d = rate_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (run_s) begin
          state_d    = ST_RUN;
          rate_cnt_d = '0;
        end else if (step_pulse_q) begin
          state_d  = ST_STEP;
          cpu_en_d = 1'b1;
        end
      end

      ST_RUN: begin
        rate_cnt_d = tick ? 6'd0 : rate_cnt_q + 6'd1;
        if (halt_req) begin
          state_d = ST_HALT;
          cause_d = CAUSE_REQ;
        end else if (tick && bp_hit) begin
          // Stop before the breakpoint instruction executes.
          state_d = ST_HALT;
          cause_d = CAUSE_BP;
        end else if (!run_s) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          cpu_en_d = 1'b1;
        end
      end

      ST_STEP: begin
        // The enable for this step was raised on entry; leave unconditionally.
        state_d = ST_IDLE;
      end

      ST_HALT: begin
        // A step here executes the instruction sitting on a breakpoint.
        if (step_pulse_q) begin
          state_d  = ST_STEP;
          cpu_en_d = 1'b1;
          cause_d  = CAUSE_NONE;
        end else if (!run_s) begin
          state_d = ST_IDLE;
          cause_d = CAUSE_NONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cause_d = CAUSE_NONE;
      end
    endcase

    cycle_count_d = cycle_count_q;
    if (cpu_en_d && (cycle_count_q != 32'hFFFF_FFFF)) begin
      cycle_count_d = cycle_count_q + 32'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cpu_en_q      <= 1'b0;
      cause_q       <= CAUSE_NONE;
      rate_cnt_q    <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cpu_en_q      <= cpu_en_d;
      cause_q       <= cause_d;
      rate_cnt_q    <= rate_cnt_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign cpu_en      = cpu_en_q;
  assign state       = state_q;
  assign halted      = (state_q == ST_HALT);
  assign halt_cause  = cause_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, giving the consecutive stable cycles needed to accept a step_btn level change.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock for all state.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port run_sw, input, 1 bit: asynchronous run switch (1 = run).
REQ-005 The block SHALL have port step_btn, input, 1 bit: asynchronous, bouncy single-step button.
REQ-006 The block SHALL have port halt_req, input, 1 bit: synchronous level from the CPU requesting halt.
REQ-007 The block SHALL have port pc, input, 32 bits: current CPU program counter.
REQ-008 The block SHALL have port bp_addr, input, 32 bits: breakpoint address.
REQ-009 The block SHALL have port bp_en, input, 1 bit: breakpoint enable.
REQ-010 The block SHALL have port rate_sel, input, 2 bits: run pulse period select, 0/1/2/3 giving 1/4/16/64 cycles.
REQ-011 The block SHALL have port cpu_en, output, 1 bit: one-cycle CPU advance enable.
REQ-012 The block SHALL have port state, output, 2 bits: FSM state, IDLE=00, RUN=01, STEP=10, HALT=11.
REQ-013 The block SHALL have port halted, output, 1 bit: high exactly when state==HALT.
REQ-014 The block SHALL have port halt_cause, output, 2 bits: 00 none, 01 halt_req, 10 breakpoint.
REQ-015 The block SHALL have port cycle_count, output, 32 bits: number of cpu_en pulses issued.

Function
REQ-016 run_sw and step_btn SHALL each pass through a 2-flop synchronizer before any other use.
REQ-017 The step debouncer SHALL count consecutive cycles in which the synchronized step_btn differs from the debounced level, clear that count on any equal cycle, and on reaching DEBOUNCE_CYCLES adopt the new level and clear the count.
REQ-018 step_pulse SHALL be a one-cycle internal pulse on each 0->1 transition of the debounced level.
REQ-019 IDLE: cpu_en=0; synchronized run_sw=1 SHALL go to RUN; otherwise step_pulse SHALL go to STEP; run takes priority over step.
REQ-020 RUN: rate_cnt SHALL be cleared on entry, increment each cycle, and produce a tick when rate_cnt >= period-1, with rate_cnt clearing on each tick.
REQ-021 A rate_sel change mid-run SHALL take effect immediately; the >= compare guarantees a tick on the next cycle if rate_cnt already exceeds the new period.
REQ-022 RUN priority per cycle SHALL be: (1) halt_req=1 -> HALT, cause 01, no pulse; (2) tick with bp_en=1 and pc==bp_addr -> HALT, cause 10, no pulse, so the breakpoint instruction is not executed; (3) synchronized run_sw=0 -> IDLE, no pulse; (4) tick -> cpu_en=1 for that cycle.
REQ-023 step_pulse SHALL be ignored in RUN.
REQ-024 STEP: cpu_en=1 for exactly the single STEP cycle, with the breakpoint and halt_req ignored, then the FSM SHALL go unconditionally to IDLE.
REQ-025 HALT: cpu_en=0 and halt_cause SHALL be held.
REQ-026 In HALT, step_pulse SHALL go to STEP, which allows stepping past a breakpoint.
REQ-027 In HALT, with no step_pulse, synchronized run_sw=0 SHALL go to IDLE; halt_req remaining high SHALL NOT block either exit.
REQ-028 halt_cause SHALL clear to 00 on any exit from HALT.
REQ-029 cpu_en SHALL be registered, with at most one pulse per cycle, and SHALL never be high in IDLE or HALT.
REQ-030 cycle_count SHALL increment on each cpu_en pulse and saturate at 0xFFFFFFFF.
REQ-031 cycle_count SHALL be cleared only by reset.

Reset
REQ-032 On reset assertion, immediately and regardless of clock: state=IDLE, cpu_en=0, halted=0, halt_cause=00, cycle_count=0.
REQ-033 Reset SHALL also clear rate_cnt, the debounce count, the debounced level and both synchronizers.
REQ-034 Reset asserted mid-RUN or mid-STEP SHALL abort with no further cpu_en pulse.
REQ-035 After reset deasserts, a step_btn already held high SHALL produce a step only after debouncing completes, with no spurious pulse before that.

Verification
REQ-036 Scenario, run at rate_sel=1: run_sw=1 held, bp_en=0 -> state=RUN on the 3rd clock edge after run_sw rises; cpu_en pulses every 4th cycle; cycle_count=5 after 20 RUN cycles.
REQ-037 Scenario, breakpoint: rate_sel=0, bp_addr=0x10, pc reaches 0x10 -> HALT with halt_cause=10, no cpu_en in that cycle, cycle_count frozen; then one step -> exactly one cpu_en, then IDLE.
REQ-038 Scenario, halt request: halt_req=1 in RUN on a tick cycle -> HALT with halt_cause=01 and no pulse; then run_sw=0 -> IDLE with halt_cause=00.
REQ-039 Scenario, bounce: DEBOUNCE_CYCLES=4; step_btn toggles every 2 cycles for 20 cycles, then held high 10 cycles -> exactly one cpu_en in total.
REQ-040 Scenario, saturation: force cycle_count to 0xFFFFFFFE, then issue 3 pulses -> cycle_count=0xFFFFFFFF.
REQ-041 Scenario, reset mid-run: reset asserted between clock edges mid-RUN -> all outputs at reset values before the next edge; no cpu_en until run_sw is re-synchronized.
